// File: rtl/osd_ascii_to_bin_reader.sv
// Reads a fixed-width ASCII decimal field (optional sign + digits) from a character RAM
// and converts it to a saturated signed 14-bit value, flagging illegal characters.
module osd_ascii_to_bin_reader #(
    parameter int SHOW_SIGN  = 1,
    parameter int NUM_DIGITS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic        [10:0] base_addr,
    output logic               rd_en,
    output logic        [10:0] rd_addr,
    input  logic        [7:0]  rd_data,
    output logic signed [13:0] value,
    output logic               done,
    output logic               error,
    output logic               ovf,
    output logic               busy
);

    localparam int N     = NUM_DIGITS + ((SHOW_SIGN != 0) ? 1 : 0);
    localparam int ACC_W = (4 * NUM_DIGITS > 14) ? 4 * NUM_DIGITS : 14;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, CHECK} state_t;

    state_t             state_q, state_d;
    logic        [10:0] base_q, base_d;
    logic        [10:0] k_q, k_d;
    logic               vld_q, vld_d;
    logic               first_q, first_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               err_q, err_d;
    logic signed [13:0] value_q;
    logic               error_q, ovf_q;

    logic [ACC_W-1:0]   acc_x10;
    logic        [13:0] mag;
    logic signed [13:0] res_val;
    logic               res_ovf;

    assign acc_x10 = (acc_q << 3) + (acc_q << 1);
    assign mag     = acc_q[13:0];
    assign busy    = (state_q != IDLE);

    // Saturated result from the accumulated magnitude; an illegal character forces zero.
    always_comb begin
        res_val = '0;
        res_ovf = 1'b0;
        if (err_q) begin
            res_val = '0;
        end else if (!neg_q && acc_q > ACC_W'(8191)) begin
            res_val = 14'sd8191;
            res_ovf = 1'b1;
        end else if (neg_q && acc_q > ACC_W'(8192)) begin
            res_val = -14'sd8192;
            res_ovf = 1'b1;
        end else begin
            res_val = neg_q ? -$signed(mag) : $signed(mag);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        vld_d   = 1'b0;
        first_d = 1'b0;
        acc_d   = acc_q;
        neg_d   = neg_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        done    = 1'b0;
        value   = value_q;
        error   = error_q;
        ovf     = ovf_q;

        if (vld_q) begin
            if (SHOW_SIGN != 0 && first_q) begin
                case (rd_data)
                    8'h2D:        neg_d = 1'b1;
                    8'h2B, 8'h20: neg_d = 1'b0;
                    default:      err_d = 1'b1;
                endcase
            end else if (rd_data >= 8'h30 && rd_data <= 8'h39) begin
                acc_d = acc_x10 + ACC_W'(rd_data[3:0]);
            end else if (rd_data == 8'h20) begin
                acc_d = acc_x10;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    k_d     = '0;
                    acc_d   = '0;
                    neg_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                rd_addr = base_q + k_q;
                vld_d   = 1'b1;
                first_d = (k_q == '0);
                k_d     = k_q + 11'd1;
                if (k_q == 11'(N - 1)) state_d = DRAIN;
            end
            DRAIN: state_d = CHECK;
            CHECK: begin
                done    = 1'b1;
                value   = res_val;
                error   = err_q;
                ovf     = res_ovf;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            k_q     <= '0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            value_q <= '0;
            error_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            vld_q   <= vld_d;
            first_q <= first_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            value_q <= value;
            error_q <= error;
            ovf_q   <= ovf;
        end
    end

endmodule

// File: tb/tb_osd_ascii_to_bin_reader.sv
// Directed bench: a signed instance (sign + 4 digits) and an unsigned instance (4 digits),
// each backed by a registered 2K-byte character RAM model.
module tb_osd_ascii_to_bin_reader;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic               start_a, start_b;
    logic        [10:0] base_a, base_b;
    logic               rd_en_a, rd_en_b;
    logic        [10:0] rd_addr_a, rd_addr_b;
    logic        [7:0]  rd_data_a, rd_data_b;
    logic signed [13:0] value_a, value_b;
    logic               done_a, done_b, error_a, error_b, ovf_a, ovf_b, busy_a, busy_b;

    logic [7:0] mem_a [2048];
    logic [7:0] mem_b [2048];

    always @(posedge clk) begin
        rd_data_a <= rd_en_a ? mem_a[rd_addr_a] : 8'h00;
        rd_data_b <= rd_en_b ? mem_b[rd_addr_b] : 8'h00;
    end

    osd_ascii_to_bin_reader #(.SHOW_SIGN(1), .NUM_DIGITS(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .base_addr(base_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .value(value_a), .done(done_a), .error(error_a), .ovf(ovf_a), .busy(busy_a)
    );

    osd_ascii_to_bin_reader #(.SHOW_SIGN(0), .NUM_DIGITS(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .base_addr(base_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .value(value_b), .done(done_b), .error(error_b), .ovf(ovf_b), .busy(busy_b)
    );

    typedef struct {
        bit          sel;      // 0: signed instance (5 chars), 1: unsigned instance (4 chars)
        logic [10:0] base;
        logic [39:0] chars;    // right-aligned, first character most significant
        int          exp_val;
        bit          exp_err;
        bit          exp_ovf;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_field(input vec_t v);
        int n;
        logic [10:0] a;
        logic [39:0] ch;
        n  = v.sel ? 4 : 5;
        ch = v.chars;
        for (int k = 0; k < n; k++) begin
            a = v.base + 11'(k);
            if (v.sel) mem_b[a] = ch[8*(n-1-k) +: 8];
            else       mem_a[a] = ch[8*(n-1-k) +: 8];
        end
    endtask

    // Called at a negedge; returns at the negedge after the done cycle so the next
    // call issues its start in the cycle right after done.
    task automatic run_conv(input vec_t v);
        int n, done_cyc, val;
        bit seq_ok, en, dn, bz;
        logic [10:0] ad;
        n = v.sel ? 4 : 5;
        load_field(v);
        if (v.sel) begin base_b = v.base; start_b = 1'b1; end
        else       begin base_a = v.base; start_a = 1'b1; end
        @(posedge clk);
        #1 start_a = 1'b0; start_b = 1'b0;
        done_cyc = -1;
        seq_ok   = 1'b1;
        val      = 0;
        for (int cyc = 1; cyc <= 20 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            en = v.sel ? rd_en_b   : rd_en_a;
            ad = v.sel ? rd_addr_b : rd_addr_a;
            dn = v.sel ? done_b    : done_a;
            bz = v.sel ? busy_b    : busy_a;
            if (en !== (cyc <= n)) seq_ok = 1'b0;
            if (cyc <= n && ad !== v.base + 11'(cyc - 1)) seq_ok = 1'b0;
            if (bz !== 1'b1) seq_ok = 1'b0;
            if (dn === 1'b1) begin
                done_cyc = cyc;
                val = v.sel ? int'(value_b) : int'(value_a);
                check("error", v.sel ? int'(error_b) : int'(error_a), int'(v.exp_err));
                check("ovf",   v.sel ? int'(ovf_b)   : int'(ovf_a),   int'(v.exp_ovf));
            end
        end
        check("rd_seq_busy", int'(seq_ok), 1);
        check("done_cycle", done_cyc, n + 2);
        check("value", val, v.exp_val);
        @(negedge clk);
        check("value_hold", v.sel ? int'(value_b) : int'(value_a), v.exp_val);
        check("idle_after", v.sel ? int'({done_b, busy_b}) : int'({done_a, busy_a}), 0);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_rd_en"},   int'(rd_en_a),   0);
        check({tag, "_rd_addr"}, int'(rd_addr_a), 0);
        check({tag, "_value"},   int'(value_a),   0);
        check({tag, "_done"},    int'(done_a),    0);
        check({tag, "_error"},   int'(error_a),   0);
        check({tag, "_ovf"},     int'(ovf_a),     0);
        check({tag, "_busy"},    int'(busy_a),    0);
    endtask

    vec_t vecs[15];

    initial begin
        int ndone, dcyc, dval;
        vec_t v;

        vecs[0]  = '{1'b0, 11'h040, "-1234", -1234, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 11'h050, "+9999",  8191, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 11'h060, "-8192", -8192, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 11'h070, "-8193", -8192, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 11'h080, "+12A4",     0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 11'h090, " 0 42",    42, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 11'h0A0, "-0000",     0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 11'h0B0, "*1234",     0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 11'h0C0, "+8191",  8191, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 11'h0D0, "+8192",  8191, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 11'h7FD, "-0001",    -1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 11'h7FE, "0057",     57, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 11'h010, "9999",   8191, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 11'h020, "12 4",   1204, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 11'h030, "-123",      0, 1'b1, 1'b0};

        reset_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        base_a  = '0;   base_b  = '0;
        #1;
        check_a_zero("reset");
        check("reset_b_busy", int'({busy_b, done_b, rd_en_b}), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_conv(vecs[i]);

        // A second start during a conversion must not disturb it or cause a second done.
        v = '{1'b0, 11'h100, "-1234", -1234, 1'b0, 1'b0};
        load_field(v);
        base_a = v.base; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        ndone = 0; dcyc = -1; dval = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 3) begin base_a = 11'h500; start_a = 1'b1; end
            if (cyc == 4) start_a = 1'b0;
            if (done_a === 1'b1) begin
                ndone++;
                if (dcyc < 0) begin dcyc = cyc; dval = int'(value_a); end
            end
        end
        check("ignore_ndone", ndone, 1);
        check("ignore_done_cycle", dcyc, 7);
        check("ignore_value", dval, -1234);

        // Reset mid-conversion: immediate zero outputs, no done, then a clean conversion.
        v = '{1'b0, 11'h200, "+0777", 777, 1'b0, 1'b0};
        load_field(v);
        base_a = v.base; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_a_zero("midreset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) ndone++;
        end
        check("after_reset_no_activity", ndone, 0);
        run_conv(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/osd_ascii_to_bin_reader.md
OSD_ASCII_TO_BIN_READER -- requirements
Module: osd_ascii_to_bin_reader

Interface
REQ-001 SHALL have parameter SHOW_SIGN, default 1, meaning field begins with one sign character before the digits.
REQ-002 SHALL have parameter NUM_DIGITS, default 4, meaning count of decimal digit characters in the field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to parse one field.
REQ-006 SHALL have port base_addr  input  11  char-RAM address of the field's first character.
REQ-007 SHALL have port rd_en  output  1  char-RAM read strobe.
REQ-008 SHALL have port rd_addr  output  11  char-RAM read address.
REQ-009 SHALL have port rd_data  input  8  ASCII byte, valid in the cycle after the matching rd_en.
REQ-010 SHALL have port value  output  14  signed parsed result, held until the next done.
REQ-011 SHALL have port done  output  1  one-cycle pulse; value/error/ovf valid.
REQ-012 SHALL have port error  output  1  field contained an illegal character.
REQ-013 SHALL have port ovf  output  1  magnitude exceeded the signed 14-bit range; result saturated.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL use states IDLE, FETCH, DRAIN, CHECK; N = NUM_DIGITS + (SHOW_SIGN ? 1 : 0).
REQ-016 In IDLE, start high at an edge SHALL latch base_addr, clear accumulator, sign and error, and enter FETCH.
REQ-017 start while busy SHALL be ignored with no effect on the conversion in progress.
REQ-018 FETCH SHALL assert rd_en for exactly N consecutive cycles, rd_addr = latched base + k for k = 0..N-1, then enter DRAIN.
REQ-019 rd_data SHALL be captured one edge after each rd_en cycle; DRAIN lasts one cycle to capture the last byte, then enters CHECK.
REQ-020 With SHOW_SIGN=1, first byte SHALL be interpreted as: 0x2D '-' gives negative; 0x2B '+' or 0x20 ' ' gives positive; any other byte sets error.
REQ-021 Each digit byte SHALL be interpreted as: 0x30-0x39 gives acc = acc*10 + (byte-0x30); 0x20 gives acc = acc*10 (blank counts as 0); any other byte sets error and leaves acc unchanged.
REQ-022 acc*10 SHALL be computed as (acc<<3)+(acc<<1) in an unsigned accumulator of at least 14 bits; for NUM_DIGITS=4, 9999 SHALL be representable without wrap.
REQ-023 CHECK SHALL produce the result as follows, and SHALL pulse done for one cycle and return to IDLE in the same cycle.
  - Positive sign, acc > 8191: value = 8191, ovf = 1.
  - Negative sign, acc > 8192: value = -8192, ovf = 1.
  - Otherwise: value = ±acc, ovf = 0.
REQ-024 When error is set, value SHALL be 0 and ovf SHALL be 0, overriding REQ-023.
REQ-025 Latency: start sampled at edge 0; rd_en SHALL be high in cycles 1..N and done in cycle N+2; busy SHALL be high in cycles 1..N+2.
REQ-026 "-0" SHALL yield value 0 with error 0.
REQ-027 rd_addr SHALL wrap modulo 2^11 when base + k exceeds 2047.
REQ-028 value, error and ovf SHALL update only in the done cycle and otherwise hold their last result.
REQ-029 Back-to-back operation: a start in the cycle after done SHALL be accepted.

Reset
REQ-030 reset_n low SHALL force state IDLE immediately, regardless of clk.
REQ-031 reset_n low SHALL force rd_en=0, rd_addr=0, value=0, done=0, error=0, ovf=0 and busy=0 immediately, regardless of clk.
REQ-032 Reset mid-conversion SHALL abort with no done pulse; the first start after reset_n deasserts SHALL run a full conversion.

Verification
REQ-033 SHOW_SIGN=1, RAM at base 0x040 holds "-1234", start -> rd_addr 0x040..0x044 on 5 consecutive cycles; done at cycle 7 with value=-1234, error=0, ovf=0.
REQ-034 SHOW_SIGN=1, RAM holds "+9999" -> value=8191, ovf=1; RAM holds "-8192" -> value=-8192, ovf=0; RAM holds "-8193" -> value=-8192, ovf=1.
REQ-035 SHOW_SIGN=1, RAM holds "+12A4" -> done with error=1, value=0; RAM holds " 0 42" -> value=42, error=0.
REQ-036 SHOW_SIGN=0, base 0x7FE, RAM holds "0057" -> rd_addr sequence 0x7FE, 0x7FF, 0x000, 0x001; value=57; done at cycle 6.
REQ-037 Second start pulsed during a conversion -> ignored, exactly one done observed; reset_n pulsed low at cycle 3 -> no done, outputs zero, next start converts correctly.
